// File: rtl/seven_seg_scanner_pkg.sv
// Shared constants, state encoding and buffer payload for the seven-segment scanner.
package seven_seg_scanner_pkg;

  localparam int unsigned NUM_DIGITS = 4;
  localparam int unsigned NIB_W      = 4;
  localparam int unsigned SEG_W      = 7;
  localparam int unsigned VALUE_W    = NUM_DIGITS * NIB_W;
  localparam int unsigned IDX_W      = $clog2(NUM_DIGITS);

  // Active-low {g,f,e,d,c,b,a}; all segments off.
  localparam logic [SEG_W-1:0] SEG_BLANK = 7'h7F;

  // Active-low hex glyphs, entry n is the pattern for nibble n.
  localparam logic [15:0][SEG_W-1:0] HEX_SEG = {
    7'b0001110,  // F
    7'b0000110,  // E
    7'b0100001,  // d
    7'b1000110,  // C
    7'b0000011,  // b
    7'b0001000,  // A
    7'b0010000,  // 9
    7'b0000000,  // 8
    7'b1111000,  // 7
    7'b0000010,  // 6
    7'b0010010,  // 5
    7'b0011001,  // 4
    7'b0110000,  // 3
    7'b0100100,  // 2
    7'b1111001,  // 1
    7'b1000000   // 0
  };

  typedef enum logic {
    ST_GAP   = 1'b0,
    ST_DRIVE = 1'b1
  } state_e;

  // One host update: digit values, per-digit enables and decimal points.
  typedef struct packed {
    logic [VALUE_W-1:0]    value;
    logic [NUM_DIGITS-1:0] en;
    logic [NUM_DIGITS-1:0] dp;
  } disp_buf_t;

  // Buffers come up showing "0000" on every digit with decimal points off.
  localparam disp_buf_t DISP_BUF_RST = '{value: '0, en: '1, dp: '0};

endpackage

// File: rtl/seven_seg_scanner_seg_hex_decode.sv
// Combinational nibble to active-low seven-segment glyph decoder.
module seven_seg_scanner_seg_hex_decode
  import seven_seg_scanner_pkg::*;
(
  input  logic [NIB_W-1:0] nib_i,
  output logic [SEG_W-1:0] seg_o
);

  // Table lookup of the glyph for this nibble.
  always_comb begin
    seg_o = HEX_SEG[nib_i];
  end

endmodule

// File: rtl/seven_seg_scanner.sv
// Time-multiplexed 4-digit common-anode display scanner with blanking gaps
// and frame-synchronous double buffering of host updates.
module seven_seg_scanner
  import seven_seg_scanner_pkg::*;
#(
  parameter int unsigned ON_CYCLES  = 50000,
  parameter int unsigned GAP_CYCLES = 500
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic [VALUE_W-1:0]    value,
  input  logic [NUM_DIGITS-1:0] digit_en,
  input  logic [NUM_DIGITS-1:0] dp_in,
  input  logic                  blank,
  output logic [NUM_DIGITS-1:0] anode,
  output logic [SEG_W-1:0]      seg,
  output logic                  dp,
  output logic                  frame_done
);

  localparam int unsigned MAX_CYC = (ON_CYCLES > GAP_CYCLES) ? ON_CYCLES : GAP_CYCLES;
  localparam int unsigned CNT_W   = $clog2(MAX_CYC + 1);
  localparam logic [CNT_W-1:0] ON_LAST  = CNT_W'(ON_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'((GAP_CYCLES > 0) ? (GAP_CYCLES - 1) : 0);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);
  // With no gap phase the scan goes straight from one DRIVE to the next.
  localparam state_e ST_START = (GAP_CYCLES == 0) ? ST_DRIVE : ST_GAP;

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  disp_buf_t          stage_q, stage_d;
  disp_buf_t          shadow_q, shadow_d;
  logic               pending_q, pending_d;
  logic [NUM_DIGITS-1:0] anode_q, anode_d;
  logic [SEG_W-1:0]   seg_q, seg_d;
  logic               dp_q, dp_d;
  logic               frame_done_q, frame_done_d;

  logic               boundary_c;
  logic               lit_c;
  disp_buf_t          host_c;
  logic [NIB_W-1:0]   nib_c;
  logic [SEG_W-1:0]   glyph_c;

  assign host_c = '{value: value, en: digit_en, dp: dp_in};

  // Nibble for the digit about to be shown, taken from the post-update shadow.
  assign nib_c = shadow_d.value[{idx_d, 2'b00} +: NIB_W];

  seven_seg_scanner_seg_hex_decode u_hex (
    .nib_i (nib_c),
    .seg_o (glyph_c)
  );

  // Scan sequencing, phase counting and staging/shadow buffer updates.
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    cnt_d      = cnt_q + CNT_W'(1);
    stage_d    = stage_q;
    shadow_d   = shadow_q;
    pending_d  = pending_q;
    boundary_c = (state_q == ST_DRIVE) && (idx_q == IDX_LAST) && (cnt_q == ON_LAST);

    unique case (state_q)
      ST_GAP: begin
        if (cnt_q == GAP_LAST) begin
          state_d = ST_DRIVE;
          cnt_d   = '0;
        end
      end
      ST_DRIVE: begin
        if (cnt_q == ON_LAST) begin
          state_d = ST_START;
          idx_d   = idx_q + IDX_W'(1);
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = ST_START;
      end
    endcase

    // A load landing on the boundary skips staging and goes live immediately.
    if (boundary_c) begin
      if (load) begin
        shadow_d  = host_c;
        pending_d = 1'b0;
      end else if (pending_q) begin
        shadow_d  = stage_q;
        pending_d = 1'b0;
      end
    end else if (load) begin
      stage_d   = host_c;
      pending_d = 1'b1;
    end
  end

  // Pin values for the upcoming cycle, derived from the next scan position.
  always_comb begin
    anode_d      = '1;
    seg_d        = SEG_BLANK;
    dp_d         = 1'b1;
    frame_done_d = boundary_c;
    lit_c        = (state_d == ST_DRIVE) && shadow_d.en[idx_d] && !blank;
    if (lit_c) begin
      anode_d = ~(NUM_DIGITS'(1) << idx_d);
      seg_d   = glyph_c;
      dp_d    = ~shadow_d.dp[idx_d];
    end
  end

  // State, buffers and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_START;
      idx_q        <= '0;
      cnt_q        <= '0;
      stage_q      <= DISP_BUF_RST;
      shadow_q     <= DISP_BUF_RST;
      pending_q    <= 1'b0;
      anode_q      <= '1;
      seg_q        <= SEG_BLANK;
      dp_q         <= 1'b1;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      cnt_q        <= cnt_d;
      stage_q      <= stage_d;
      shadow_q     <= shadow_d;
      pending_q    <= pending_d;
      anode_q      <= anode_d;
      seg_q        <= seg_d;
      dp_q         <= dp_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign anode      = anode_q;
  assign seg        = seg_q;
  assign dp         = dp_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_seven_seg_scanner.sv
// Directed table-driven bench for seven_seg_scanner (ON=4, GAP=1 and ON=4, GAP=0).
module tb_seven_seg_scanner;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Instance with a one-cycle gap: frame = 20 cycles.
  logic        rst, load, blank, dp, frame_done;
  logic [15:0] value;
  logic [3:0]  digit_en, dp_in, anode;
  logic [6:0]  seg;

  // Instance without a gap phase: frame = 16 cycles.
  logic        rst0, load0, blank0, dp0, frame_done0;
  logic [15:0] value0;
  logic [3:0]  en0, dp_in0, anode0;
  logic [6:0]  seg0;

  seven_seg_scanner #(.ON_CYCLES(4), .GAP_CYCLES(1)) dut (
    .clk(clk), .rst(rst), .load(load), .value(value), .digit_en(digit_en),
    .dp_in(dp_in), .blank(blank), .anode(anode), .seg(seg), .dp(dp),
    .frame_done(frame_done)
  );

  seven_seg_scanner #(.ON_CYCLES(4), .GAP_CYCLES(0)) dut0 (
    .clk(clk), .rst(rst0), .load(load0), .value(value0), .digit_en(en0),
    .dp_in(dp_in0), .blank(blank0), .anode(anode0), .seg(seg0), .dp(dp0),
    .frame_done(frame_done0)
  );

  typedef struct packed {
    int         t;
    logic [3:0] anode;
    logic [6:0] seg;
    logic       dp;
  } chk_t;

  typedef struct packed {
    int          t;
    logic        load;
    logic [15:0] value;
    logic [3:0]  en;
    logic [3:0]  dp;
    logic        blank;
  } stim_t;

  chk_t  chk_q[$];
  chk_t  chk0_q[$];
  stim_t stim_q[$];

  int checks   = 0;
  int failures = 0;

  function automatic chk_t mk_chk(int t, logic [3:0] a, logic [6:0] s, logic d);
    chk_t c;
    c.t = t; c.anode = a; c.seg = s; c.dp = d;
    return c;
  endfunction

  function automatic stim_t mk_stim(int t, logic l, logic [15:0] v, logic [3:0] e,
                                    logic [3:0] d, logic b);
    stim_t s;
    s.t = t; s.load = l; s.value = v; s.en = e; s.dp = d; s.blank = b;
    return s;
  endfunction

  task automatic check_disp(string name, int t, logic [3:0] a, logic [6:0] s, logic d,
                            logic [3:0] ea, logic [6:0] es, logic ed);
    checks++;
    if ({a, s, d} !== {ea, es, ed}) begin
      failures++;
      $display("FAIL %s t=%0d got anode=%b seg=%b dp=%b want anode=%b seg=%b dp=%b",
               name, t, a, s, d, ea, es, ed);
    end
  endtask

  task automatic check_bit(string name, int t, logic got, logic want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s t=%0d got %b want %b", name, t, got, want);
    end
  endtask

  initial begin
    rst = 1'b1; load = 1'b0; value = '0; digit_en = '0; dp_in = '0; blank = 1'b0;
    rst0 = 1'b1; load0 = 1'b0; value0 = '0; en0 = 4'hF; dp_in0 = '0; blank0 = 1'b0;

    // Frame 0 (reset contents "0000"): gap then digit sweep.
    chk_q.push_back(mk_chk(0,   4'b1111, 7'b1111111, 1'b1));
    chk_q.push_back(mk_chk(1,   4'b1110, 7'b1000000, 1'b1));
    chk_q.push_back(mk_chk(4,   4'b1110, 7'b1000000, 1'b1));
    chk_q.push_back(mk_chk(5,   4'b1111, 7'b1111111, 1'b1));
    chk_q.push_back(mk_chk(6,   4'b1101, 7'b1000000, 1'b1));
    chk_q.push_back(mk_chk(11,  4'b1011, 7'b1000000, 1'b1));
    chk_q.push_back(mk_chk(16,  4'b0111, 7'b1000000, 1'b1));
    chk_q.push_back(mk_chk(19,  4'b0111, 7'b1000000, 1'b1));
    chk_q.push_back(mk_chk(20,  4'b1111, 7'b1111111, 1'b1));
    // Frame 1: 8F10 with dp on digit 2.
    chk_q.push_back(mk_chk(21,  4'b1110, 7'b1000000, 1'b1));
    chk_q.push_back(mk_chk(26,  4'b1101, 7'b1111001, 1'b1));
    chk_q.push_back(mk_chk(31,  4'b1011, 7'b0001110, 1'b0));
    chk_q.push_back(mk_chk(34,  4'b1011, 7'b0001110, 1'b0));
    chk_q.push_back(mk_chk(36,  4'b0111, 7'b0000000, 1'b1));
    chk_q.push_back(mk_chk(40,  4'b1111, 7'b1111111, 1'b1));
    // Frame 2 still 8F10 while 1111/2222 are staged.
    chk_q.push_back(mk_chk(46,  4'b1101, 7'b1111001, 1'b1));
    chk_q.push_back(mk_chk(51,  4'b1011, 7'b0001110, 1'b0));
    // Frame 3: only 2222 appears.
    chk_q.push_back(mk_chk(61,  4'b1110, 7'b0100100, 1'b1));
    chk_q.push_back(mk_chk(66,  4'b1101, 7'b0100100, 1'b1));
    chk_q.push_back(mk_chk(76,  4'b0111, 7'b0100100, 1'b1));
    // Frame 4: 3A5C loaded on the boundary cycle, dp on digit 3.
    chk_q.push_back(mk_chk(81,  4'b1110, 7'b1000110, 1'b1));
    chk_q.push_back(mk_chk(86,  4'b1101, 7'b0010010, 1'b1));
    chk_q.push_back(mk_chk(91,  4'b1011, 7'b0001000, 1'b1));
    chk_q.push_back(mk_chk(96,  4'b0111, 7'b0110000, 1'b0));
    // Frame 5 unchanged (no stale pending copy of the staged 2222).
    chk_q.push_back(mk_chk(106, 4'b1101, 7'b0010010, 1'b1));
    chk_q.push_back(mk_chk(116, 4'b0111, 7'b0110000, 1'b0));
    // Frame 6: 4321 with only digits 0 and 2 enabled.
    chk_q.push_back(mk_chk(121, 4'b1110, 7'b1111001, 1'b1));
    chk_q.push_back(mk_chk(126, 4'b1111, 7'b1111111, 1'b1));
    chk_q.push_back(mk_chk(131, 4'b1011, 7'b0110000, 1'b1));
    chk_q.push_back(mk_chk(136, 4'b1111, 7'b1111111, 1'b1));
    // Frame 7: blank raised at 142, dropped at 150.
    chk_q.push_back(mk_chk(142, 4'b1110, 7'b1111001, 1'b1));
    chk_q.push_back(mk_chk(143, 4'b1111, 7'b1111111, 1'b1));
    chk_q.push_back(mk_chk(144, 4'b1111, 7'b1111111, 1'b1));
    chk_q.push_back(mk_chk(151, 4'b1011, 7'b0110000, 1'b1));

    stim_q.push_back(mk_stim(8,   1'b1, 16'h8F10, 4'b1111, 4'b0100, 1'b0));
    stim_q.push_back(mk_stim(42,  1'b1, 16'h1111, 4'b1111, 4'b0000, 1'b0));
    stim_q.push_back(mk_stim(45,  1'b1, 16'h2222, 4'b1111, 4'b0000, 1'b0));
    stim_q.push_back(mk_stim(79,  1'b1, 16'h3A5C, 4'b1111, 4'b1000, 1'b0));
    stim_q.push_back(mk_stim(102, 1'b1, 16'h4321, 4'b0101, 4'b0000, 1'b0));
    stim_q.push_back(mk_stim(142, 1'b0, 16'h0000, 4'b0000, 4'b0000, 1'b1));
    stim_q.push_back(mk_stim(150, 1'b0, 16'h0000, 4'b0000, 4'b0000, 1'b0));

    // No-gap build: back-to-back digits, reset in DRIVE(2) at 41 discards the FFFF load.
    chk0_q.push_back(mk_chk(0,  4'b1111, 7'b1111111, 1'b1));
    chk0_q.push_back(mk_chk(1,  4'b1110, 7'b1000000, 1'b1));
    chk0_q.push_back(mk_chk(3,  4'b1110, 7'b1000000, 1'b1));
    chk0_q.push_back(mk_chk(4,  4'b1101, 7'b1000000, 1'b1));
    chk0_q.push_back(mk_chk(8,  4'b1011, 7'b1000000, 1'b1));
    chk0_q.push_back(mk_chk(12, 4'b0111, 7'b1000000, 1'b1));
    chk0_q.push_back(mk_chk(15, 4'b0111, 7'b1000000, 1'b1));
    chk0_q.push_back(mk_chk(16, 4'b1110, 7'b1000000, 1'b1));
    chk0_q.push_back(mk_chk(40, 4'b1011, 7'b1000000, 1'b1));
    chk0_q.push_back(mk_chk(42, 4'b1111, 7'b1111111, 1'b1));
    chk0_q.push_back(mk_chk(43, 4'b1110, 7'b1000000, 1'b1));
    chk0_q.push_back(mk_chk(46, 4'b1101, 7'b1000000, 1'b1));
    chk0_q.push_back(mk_chk(59, 4'b1110, 7'b1000000, 1'b1));

    repeat (3) @(negedge clk);

    for (int t = 0; t < 165; t++) begin
      foreach (chk_q[k])
        if (chk_q[k].t == t)
          check_disp("gap_scan", t, anode, seg, dp, chk_q[k].anode, chk_q[k].seg, chk_q[k].dp);
      check_bit("frame_done", t, frame_done, (t > 0) && (t % 20 == 0));
      if (t == 0) rst = 1'b0;
      load = 1'b0;
      foreach (stim_q[k])
        if (stim_q[k].t == t) begin
          load     = stim_q[k].load;
          value    = stim_q[k].value;
          digit_en = stim_q[k].en;
          dp_in    = stim_q[k].dp;
          blank    = stim_q[k].blank;
        end
      @(negedge clk);
    end

    for (int t = 0; t < 70; t++) begin
      int org;
      org = (t >= 42) ? 42 : 0;
      foreach (chk0_q[k])
        if (chk0_q[k].t == t)
          check_disp("nogap_scan", t, anode0, seg0, dp0,
                     chk0_q[k].anode, chk0_q[k].seg, chk0_q[k].dp);
      check_bit("nogap_frame_done", t, frame_done0, (t > org) && ((t - org) % 16 == 0));
      if (t == 0)  rst0 = 1'b0;
      if (t == 41) rst0 = 1'b1;
      if (t == 42) rst0 = 1'b0;
      load0 = (t == 38);
      if (t == 38) value0 = 16'hFFFF;
      @(negedge clk);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
